fifo_word_reader: RTL and testbench
===================================

# fifo_word_reader

Read-side consumer for the BRAM FIFO buffer. Pulls one byte (`COLS` bits) at a time through the FIFO's read trigger/done handshake and packs `WORD_BYTES` consecutive bytes into one word, first byte in the least-significant position. Presents the word to a downstream block over a valid/ready handshake. Sits between the FIFO that buffers incoming command bytes and the command decoder that wants whole fields.

## Interface
- `COLS`, default `BYTE_BITS` (8): width of one FIFO row.
- `WORD_BYTES`, default 4: FIFO rows per output word; legal range ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `clk_en`  in  1  module enable; all state advances only in cycles with `clk_en`=1.
- `fifo_is_empty`  in  1  FIFO has no readable row.
- `fifo_rd_rdy`  in  1  FIFO accepts a read trigger.
- `fifo_rd_done`  in  1  one-cycle pulse; `fifo_rd_data` valid in the same cycle.
- `fifo_rd_data`  in  COLS  row read from FIFO.
- `fifo_rd_trigger`  out  1  read request to FIFO; registered.
- `flush`  in  1  discard any partially assembled word.
- `word_rdy`  in  1  downstream accepts word.
- `word_valid`  out  1  `word_data` holds a complete word.
- `word_data`  out  COLS*WORD_BYTES  assembled word; byte k at bits [k*COLS +: COLS].
- `busy`  out  1  a FIFO read is outstanding (state WAIT).

## Operation
- States: IDLE, REQ, WAIT, HOLD. Reset state IDLE, byte count 0, `word_data` 0, all outputs 0.
- IDLE: if `fifo_rd_rdy` && !`fifo_is_empty`, go to REQ.
- REQ: `fifo_rd_trigger`=1 for exactly this one enabled cycle; go to WAIT.
- WAIT: `busy`=1. On `fifo_rd_done`, write `fifo_rd_data` into byte slot `count`. If `count`==WORD_BYTES-1, clear count and go to HOLD; otherwise increment count and go to IDLE.
- HOLD: `word_valid`=1, `word_data` stable. On `word_rdy`, go to IDLE. No new FIFO read is issued while in HOLD.
- Flush in IDLE, REQ or HOLD clears count, clears `word_valid`, and sets state IDLE. A flush in REQ still lets the trigger cycle complete; the read is then tracked as a pending discard.
- Flush in WAIT sets a pending-flush flag. When `fifo_rd_done` arrives, the byte is discarded, count is cleared, and state goes to IDLE. The FIFO handshake is never abandoned mid-read.
- Byte slots not yet written in the current word keep stale contents; only a complete word is ever presented.
- Count width is `$clog2(WORD_BYTES)`; count never exceeds WORD_BYTES-1.

## Timing
- All inputs are sampled and all state updates occur only on rising edges with `clk_en`=1. With `clk_en`=0, outputs hold.
- Per-byte cost: 1 cycle IDLE + 1 cycle REQ + FIFO read latency L (REQ to `fifo_rd_done`). All cycles are enabled cycles.
- `word_valid` rises on the cycle after the last byte's `rd_done`. It falls the cycle after acceptance (`word_rdy`=1 sampled in HOLD).
- `fifo_rd_done` outside WAIT is ignored.
- `word_rdy` and `flush` in the same HOLD cycle: flush wins and the word is not counted as delivered.
- FIFO empty: the block stays in IDLE indefinitely; a partial word is retained.
- Reset in any state, including WAIT: returns to reset values next edge and `fifo_rd_trigger` drops immediately. The outstanding FIFO read is the FIFO's concern, since both share `reset`.

## Structure
- Package `fifo_reader_pkg`: state enum typedef (IDLE, REQ, WAIT, HOLD).
- Single module. Byte-slot write is an indexed part-select on a registered word; no sub-module needed.

## Test plan
- WORD_BYTES=4, FIFO preloaded 0x11,0x22,0x33,0x44, `word_rdy`=1 → one `word_valid` pulse with `word_data`=0x44332211; exactly 4 `fifo_rd_trigger` pulses.
- FIFO holds 6 bytes 0x01..0x06 → word 0x04030201 delivered; block then idles with count=2 while FIFO is empty. Push 0x07,0x08 → word 0x08070605.
- Backpressure: `word_rdy`=0 for 10 cycles in HOLD → `word_data` stable, no `fifo_rd_trigger`; `word_rdy`=1 → IDLE next cycle.
- Flush asserted during WAIT after 2 bytes → third byte read completes and is discarded. Next 4 bytes 0xA0..0xA3 → word 0xA3A2A1A0.
- `clk_en` toggled 1-of-3 cycles during a full word → same word as the continuous case, with the trigger held for one enabled cycle only.
- Reset asserted in WAIT → next cycle all outputs 0, state IDLE, count 0.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared types for the FIFO word reader: default row width and the read-side FSM states.
package fifo_reader_pkg;

    localparam int BYTE_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_word_reader.sv
// Pulls bytes from the BRAM FIFO one read at a time and packs WORD_BYTES of them
// (first byte in the LSBs) into a word offered downstream over valid/ready.
//
// state | meaning
// IDLE  | waiting for a readable FIFO row (or for a discarded read to drain)
// REQ   | fifo_rd_trigger high for this one enabled cycle
// WAIT  | read outstanding, waiting for fifo_rd_done
// HOLD  | complete word presented, waiting for word_rdy
module fifo_word_reader
    import fifo_reader_pkg::*;
#(
    parameter int COLS       = BYTE_BITS,
    parameter int WORD_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic                       fifo_is_empty,
    input  logic                       fifo_rd_rdy,
    input  logic                       fifo_rd_done,
    input  logic [COLS-1:0]            fifo_rd_data,
    output logic                       fifo_rd_trigger,
    input  logic                       flush,
    input  logic                       word_rdy,
    output logic                       word_valid,
    output logic [COLS*WORD_BYTES-1:0] word_data,
    output logic                       busy
);

    localparam int            CW   = $clog2(WORD_BYTES);
    localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

    rd_state_t     state;
    logic [CW-1:0] count;
    logic          flush_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            flush_pend      <= 1'b0;
            word_data       <= '0;
            fifo_rd_trigger <= 1'b0;
            word_valid      <= 1'b0;
            busy            <= 1'b0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    // A read flushed in REQ is still in flight; swallow its done first.
                    if (flush_pend && fifo_rd_done) begin
                        flush_pend <= 1'b0;
                    end
                    if (flush) begin
                        count <= '0;
                    end else if (fifo_rd_rdy && !fifo_is_empty && !flush_pend) begin
                        state           <= REQ;
                        fifo_rd_trigger <= 1'b1;
                    end
                end
                REQ: begin
                    fifo_rd_trigger <= 1'b0;
                    if (flush) begin
                        count      <= '0;
                        flush_pend <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        state <= WAIT;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (fifo_rd_done) begin
                        busy       <= 1'b0;
                        flush_pend <= 1'b0;
                        if (flush || flush_pend) begin
                            count <= '0;
                            state <= IDLE;
                        end else begin
                            word_data[count*COLS +: COLS] <= fifo_rd_data;
                            if (count == LAST) begin
                                count      <= '0;
                                state      <= HOLD;
                                word_valid <= 1'b1;
                            end else begin
                                count <= count + 1'b1;
                                state <= IDLE;
                            end
                        end
                    end else if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                HOLD: begin
                    // Flush beats word_rdy: the word is dropped, not delivered.
                    if (flush || word_rdy) begin
                        state      <= IDLE;
                        word_valid <= 1'b0;
                        count      <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader with a FIFO model and a word-level scoreboard.
module tb_fifo_word_reader;

    localparam int COLS = 8;
    localparam int WB   = 4;
    localparam int W    = COLS * WB;

    logic          clk = 1'b0;
    logic          reset, clk_en, fifo_is_empty, fifo_rd_rdy, fifo_rd_done;
    logic [COLS-1:0] fifo_rd_data;
    logic          fifo_rd_trigger, flush, word_rdy, word_valid, busy;
    logic [W-1:0]  word_data;

    int vectors     = 0;
    int miscompares = 0;

    fifo_word_reader #(.COLS(COLS), .WORD_BYTES(WB)) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_en          (clk_en),
        .fifo_is_empty   (fifo_is_empty),
        .fifo_rd_rdy     (fifo_rd_rdy),
        .fifo_rd_done    (fifo_rd_done),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_rd_trigger (fifo_rd_trigger),
        .flush           (flush),
        .word_rdy        (word_rdy),
        .word_valid      (word_valid),
        .word_data       (word_data),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: row contents plus a fixed read latency counted in enabled cycles.
    logic [COLS-1:0] fq[$];

    task automatic push(input logic [COLS-1:0] b);
        fq.push_back(b);
        fifo_is_empty = 1'b0;
    endtask

    initial begin
        logic f_trig, f_en, f_rst, f_done;
        int   lat;
        fifo_rd_done = 1'b0;
        fifo_rd_data = '0;
        lat = -1;
        forever begin
            @(posedge clk);
            f_trig = fifo_rd_trigger;
            f_en   = clk_en;
            f_rst  = reset;
            f_done = fifo_rd_done;
            #1;
            if (f_rst) begin
                fifo_rd_done = 1'b0;
                lat = -1;
                fq.delete();
                fifo_is_empty = 1'b1;
            end else if (f_en) begin
                if (f_done) fifo_rd_done = 1'b0;
                if (lat > 0) begin
                    lat--;
                end else if (lat == 0) begin
                    fifo_rd_done = 1'b1;
                    fifo_rd_data = (fq.size() > 0) ? fq.pop_front() : 8'hEE;
                    fifo_is_empty = (fq.size() == 0);
                    lat = -1;
                end
                if (f_trig) lat = 1;
            end
        end
    end

    // Scoreboard: bytes handed over by the FIFO, grouped into words, minus flushed ones.
    logic [COLS-1:0] acc[$];
    logic            pend_valid = 1'b0;
    logic [W-1:0]    pend_word  = '0;
    logic            outstanding = 1'b0;
    logic            discard = 1'b0;
    int              trig_count = 0;
    logic [W-1:0]    dut_words[$];

    initial begin
        logic c_en, c_rst, c_trig, c_done, c_flush, c_rdy;
        logic [COLS-1:0] c_byte;
        logic [W-1:0]    c_data;
        forever begin
            @(posedge clk);
            c_en = clk_en; c_rst = reset; c_trig = fifo_rd_trigger; c_done = fifo_rd_done;
            c_flush = flush; c_rdy = word_rdy; c_byte = fifo_rd_data; c_data = word_data;
            if (c_rst) begin
                acc.delete();
                pend_valid = 1'b0;
                outstanding = 1'b0;
                discard = 1'b0;
            end else if (c_en) begin
                if (c_flush) begin
                    acc.delete();
                    pend_valid = 1'b0;
                    if (outstanding) discard = 1'b1;
                end else if (pend_valid && c_rdy) begin
                    pend_valid = 1'b0;
                    dut_words.push_back(c_data);
                end
                if (c_done && outstanding) begin
                    outstanding = 1'b0;
                    if (discard) begin
                        discard = 1'b0;
                        acc.delete();
                    end else begin
                        acc.push_back(c_byte);
                        if (acc.size() == WB) begin
                            for (int k = 0; k < WB; k++) pend_word[k*COLS +: COLS] = acc[k];
                            pend_valid = 1'b1;
                            acc.delete();
                        end
                    end
                end
                if (c_trig) begin
                    trig_count++;
                    outstanding = 1'b1;
                end
            end
            @(negedge clk);
            check("word_valid", W'(word_valid), W'(pend_valid));
            check("busy", W'(busy), W'(outstanding));
            if (pend_valid) check("word_data", word_data, pend_word);
            if (c_en && c_trig && !c_rst) check("trigger_one_cycle", W'(fifo_rd_trigger), '0);
            if (fifo_rd_trigger) check("trigger_while_held", W'({pend_valid, outstanding}), '0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 400 && dut_words.size() < n; i++) cyc();
        check("word_count", W'(dut_words.size()), W'(n));
    endtask

    initial begin
        int base, t0;
        reset = 1'b1; clk_en = 1'b1; flush = 1'b0; word_rdy = 1'b1;
        fifo_rd_rdy = 1'b1; fifo_is_empty = 1'b1;
        repeat (3) cyc();
        check("rst_trigger", W'(fifo_rd_trigger), '0);
        check("rst_valid", W'(word_valid), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_data", word_data, '0);
        reset = 1'b0;
        cyc();

        // Single word
        t0 = trig_count;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_words(1);
        check("word1", dut_words[0], 32'h44332211);
        check("word1_triggers", W'(trig_count - t0), W'(4));

        // Six bytes: one word plus a retained partial word
        base = dut_words.size(); t0 = trig_count;
        for (int b = 1; b <= 6; b++) push(8'(b));
        wait_words(base + 1);
        check("word2", dut_words[base], 32'h04030201);
        repeat (60) cyc();
        check("partial_triggers", W'(trig_count - t0), W'(6));
        check("partial_bytes", W'(acc.size()), W'(2));
        check("partial_no_word", W'(dut_words.size()), W'(base + 1));
        push(8'h07); push(8'h08);
        wait_words(base + 2);
        check("word3", dut_words[base + 1], 32'h08070605);

        // Backpressure for 10 cycles
        base = dut_words.size();
        word_rdy = 1'b0;
        push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
        for (int i = 0; i < 300 && !word_valid; i++) cyc();
        t0 = trig_count;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("bp_data", word_data, 32'hC3C2C1C0);
            check("bp_trigger", W'(fifo_rd_trigger), '0);
        end
        word_rdy = 1'b1;
        cyc();
        check("bp_release", W'(word_valid), '0);
        check("bp_no_reads", W'(trig_count - t0), '0);
        check("bp_word", dut_words[base], 32'hC3C2C1C0);

        // Flush while the third byte is outstanding
        base = dut_words.size(); t0 = trig_count;
        push(8'hB0); push(8'hB1); push(8'hB2);
        for (int i = 0; i < 300 && !(acc.size() == 2 && busy); i++) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 50 && busy; i++) cyc();
        repeat (3) cyc();
        check("flush_idle", W'(busy), '0);
        check("flush_drained", W'(fq.size()), '0);
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        wait_words(base + 1);
        check("flush_word", dut_words[base], 32'hA3A2A1A0);
        check("flush_triggers", W'(trig_count - t0), W'(7));

        // Enable active one cycle in three
        base = dut_words.size(); t0 = trig_count;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int i = 0; i < 900 && dut_words.size() <= base; i++) begin
            clk_en = (i % 3 == 0);
            cyc();
        end
        clk_en = 1'b1;
        check("clken_count", W'(dut_words.size()), W'(base + 1));
        check("clken_word", dut_words[base], 32'h44332211);
        check("clken_triggers", W'(trig_count - t0), W'(4));

        // Flush and word_rdy together in HOLD: word dropped
        base = dut_words.size();
        word_rdy = 1'b0;
        push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
        for (int i = 0; i < 300 && !word_valid; i++) cyc();
        check("hold_reached", W'(word_valid), W'(1));
        flush = 1'b1; word_rdy = 1'b1;
        cyc();
        flush = 1'b0;
        check("flush_wins_valid", W'(word_valid), '0);
        check("flush_wins_count", W'(dut_words.size()), W'(base));

        // Reset during WAIT
        push(8'h55); push(8'h66);
        for (int i = 0; i < 100 && !busy; i++) cyc();
        check("wait_reached", W'(busy), W'(1));
        reset = 1'b1;
        cyc();
        check("wrst_trigger", W'(fifo_rd_trigger), '0);
        check("wrst_valid", W'(word_valid), '0);
        check("wrst_busy", W'(busy), '0);
        check("wrst_data", word_data, '0);
        reset = 1'b0;
        cyc();

        // Count restarts from zero after reset
        base = dut_words.size();
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        wait_words(base + 1);
        check("post_rst_word", dut_words[base], 32'hE4E3E2E1);

        repeat (5) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
